// File: rtl/me266_pkg.sv
// Shared widths, default FIFO depths and word types for the me266 fetch path.
package me266_pkg;

  localparam int REF_W     = 64;
  localparam int CUR_W     = 32;
  localparam int REF_DEPTH = 8;
  localparam int CUR_DEPTH = 4;

  typedef logic [REF_W-1:0] ref_word_t;
  typedef logic [CUR_W-1:0] cur_word_t;

endpackage

// File: rtl/me_sync_fifo.sv
// Single-clock FIFO with a separate 0..DEPTH occupancy counter; the head word is
// visible combinationally on rdata_o. Pushes when full and pops when empty are ignored.
module me_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the level counter gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/me266_fetch_buf.sv
// Reference/current word feeder for the me266 core: two independent FIFOs with
// registered output words and sticky underrun flags. Optional macro: ME_FETCH_BYPASS_EN.
module me266_fetch_buf #(
  parameter int REF_W     = me266_pkg::REF_W,
  parameter int CUR_W     = me266_pkg::CUR_W,
  parameter int REF_DEPTH = me266_pkg::REF_DEPTH,
  parameter int CUR_DEPTH = me266_pkg::CUR_DEPTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [REF_W-1:0]             ref_wdata,
  input  logic                         ref_wvalid,
  output logic                         ref_wready,
  input  logic [CUR_W-1:0]             cur_wdata,
  input  logic                         cur_wvalid,
  output logic                         cur_wready,
  input  logic                         ref_read,
  input  logic                         cur_read,
  output logic [REF_W-1:0]             ref_in,
  output logic [CUR_W-1:0]             cur_in,
  output logic [$clog2(REF_DEPTH):0]   ref_level,
  output logic [$clog2(CUR_DEPTH):0]   cur_level,
  output logic                         ref_underrun,
  output logic                         cur_underrun
);

  import me266_pkg::*;

  // Handshake: a write word transfers on a clk edge where X_wvalid && X_wready;
  // X_wready depends only on registered occupancy, never on X_wvalid.
  logic             ref_full, ref_empty, cur_full, cur_empty;
  logic [REF_W-1:0] ref_head;
  logic [CUR_W-1:0] cur_head;
  logic             ref_push, ref_fifo_push, ref_pop, ref_bypass, ref_urun_set;
  logic             cur_push, cur_fifo_push, cur_pop, cur_bypass, cur_urun_set;

  logic [REF_W-1:0] ref_in_q, ref_in_d;
  logic [CUR_W-1:0] cur_in_q, cur_in_d;
  logic             ref_urun_q, ref_urun_d;
  logic             cur_urun_q, cur_urun_d;

  assign ref_wready = !ref_full;
  assign cur_wready = !cur_full;
  assign ref_push   = ref_wvalid && ref_wready;
  assign cur_push   = cur_wvalid && cur_wready;

`ifdef ME_FETCH_BYPASS_EN
  // Empty FIFO with a read and a write in the same cycle: hand the word straight to the core.
  assign ref_bypass = ref_read && ref_empty && ref_push;
  assign cur_bypass = cur_read && cur_empty && cur_push;
`else
  assign ref_bypass = 1'b0;
  assign cur_bypass = 1'b0;
`endif

  assign ref_fifo_push = ref_push && !ref_bypass;
  assign cur_fifo_push = cur_push && !cur_bypass;
  assign ref_pop       = ref_read && !ref_empty;
  assign cur_pop       = cur_read && !cur_empty;
  assign ref_urun_set  = ref_read && ref_empty && !ref_bypass;
  assign cur_urun_set  = cur_read && cur_empty && !cur_bypass;

  me_sync_fifo #(.WIDTH(REF_W), .DEPTH(REF_DEPTH)) u_ref_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (ref_fifo_push),
    .wdata_i (ref_wdata),
    .pop_i   (ref_pop),
    .rdata_o (ref_head),
    .full_o  (ref_full),
    .empty_o (ref_empty),
    .level_o (ref_level)
  );

  me_sync_fifo #(.WIDTH(CUR_W), .DEPTH(CUR_DEPTH)) u_cur_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (cur_fifo_push),
    .wdata_i (cur_wdata),
    .pop_i   (cur_pop),
    .rdata_o (cur_head),
    .full_o  (cur_full),
    .empty_o (cur_empty),
    .level_o (cur_level)
  );

  always_comb begin
    ref_in_d   = ref_in_q;
    cur_in_d   = cur_in_q;
    ref_urun_d = ref_urun_q || ref_urun_set;
    cur_urun_d = cur_urun_q || cur_urun_set;
    if (ref_bypass)   ref_in_d = ref_wdata;
    else if (ref_pop) ref_in_d = ref_head;
    if (cur_bypass)   cur_in_d = cur_wdata;
    else if (cur_pop) cur_in_d = cur_head;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ref_in_q   <= '0;
      cur_in_q   <= '0;
      ref_urun_q <= 1'b0;
      cur_urun_q <= 1'b0;
    end else begin
      ref_in_q   <= ref_in_d;
      cur_in_q   <= cur_in_d;
      ref_urun_q <= ref_urun_d;
      cur_urun_q <= cur_urun_d;
    end
  end

  assign ref_in       = ref_in_q;
  assign cur_in       = cur_in_q;
  assign ref_underrun = ref_urun_q;
  assign cur_underrun = cur_urun_q;

endmodule

// File: tb/tb_me266_fetch_buf.sv
// Self-checking bench for me266_fetch_buf: per-scenario tasks with a queue-based
// reference model of both streams.
module tb_me266_fetch_buf;

  logic        clk;
  logic        rstn;
  logic [63:0] ref_wdata;
  logic        ref_wvalid;
  logic        ref_wready;
  logic [31:0] cur_wdata;
  logic        cur_wvalid;
  logic        cur_wready;
  logic        ref_read;
  logic        cur_read;
  logic [63:0] ref_in;
  logic [31:0] cur_in;
  logic [3:0]  ref_level;
  logic [2:0]  cur_level;
  logic        ref_underrun;
  logic        cur_underrun;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model
  logic [63:0] r_exp_q[$];
  logic [31:0] c_exp_q[$];
  logic [63:0] r_exp_in;
  logic [31:0] c_exp_in;
  bit          r_urun;
  bit          c_urun;

  me266_fetch_buf dut (
    .clk          (clk),
    .rstn         (rstn),
    .ref_wdata    (ref_wdata),
    .ref_wvalid   (ref_wvalid),
    .ref_wready   (ref_wready),
    .cur_wdata    (cur_wdata),
    .cur_wvalid   (cur_wvalid),
    .cur_wready   (cur_wready),
    .ref_read     (ref_read),
    .cur_read     (cur_read),
    .ref_in       (ref_in),
    .cur_in       (cur_in),
    .ref_level    (ref_level),
    .cur_level    (cur_level),
    .ref_underrun (ref_underrun),
    .cur_underrun (cur_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    r_exp_q.delete();
    c_exp_q.delete();
    r_exp_in = '0;
    c_exp_in = '0;
    r_urun   = 0;
    c_urun   = 0;
  endtask

  task automatic drive_idle();
    ref_wvalid = 1'b0;
    ref_wdata  = '0;
    ref_read   = 1'b0;
    cur_wvalid = 1'b0;
    cur_wdata  = '0;
    cur_read   = 1'b0;
  endtask

  // Called at a negedge; drives one cycle and updates the model for the coming posedge.
  task automatic step(input logic rv, input logic [63:0] rd, input logic rr,
                      input logic cv, input logic [31:0] cd, input logic cr);
    bit r_acc, c_acc, r_byp, c_byp;
    ref_wvalid = rv;
    ref_wdata  = rd;
    ref_read   = rr;
    cur_wvalid = cv;
    cur_wdata  = cd;
    cur_read   = cr;
    r_acc = rv && (r_exp_q.size() != 8);
    c_acc = cv && (c_exp_q.size() != 4);
    r_byp = 0;
    c_byp = 0;
`ifdef ME_FETCH_BYPASS_EN
    r_byp = rr && (r_exp_q.size() == 0) && r_acc;
    c_byp = cr && (c_exp_q.size() == 0) && c_acc;
`endif
    if (r_byp)                          r_exp_in = rd;
    else if (rr && r_exp_q.size() != 0) r_exp_in = r_exp_q.pop_front();
    else if (rr)                        r_urun = 1;
    if (r_acc && !r_byp) r_exp_q.push_back(rd);
    if (c_byp)                          c_exp_in = cd;
    else if (cr && c_exp_q.size() != 0) c_exp_in = c_exp_q.pop_front();
    else if (cr)                        c_urun = 1;
    if (c_acc && !c_byp) c_exp_q.push_back(cd);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
  endtask

  task automatic apply_reset();
    drive_idle();
    @(negedge clk);
    rstn = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    drive_idle();
    model_clear();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_cnt++; if (ref_in !== 64'h0) $display("FAIL reset_ref_in got=%h exp=0", ref_in); else pass_cnt++;
    chk_cnt++; if (cur_in !== 32'h0) $display("FAIL reset_cur_in got=%h exp=0", cur_in); else pass_cnt++;
    chk_cnt++; if (ref_level !== 4'd0) $display("FAIL reset_ref_level got=%0d exp=0", ref_level); else pass_cnt++;
    chk_cnt++; if (cur_level !== 3'd0) $display("FAIL reset_cur_level got=%0d exp=0", cur_level); else pass_cnt++;
    chk_cnt++; if (ref_underrun !== 1'b0 || cur_underrun !== 1'b0)
      $display("FAIL reset_underrun got=%b%b exp=00", ref_underrun, cur_underrun); else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk_cnt++; if (ref_wready !== 1'b1 || cur_wready !== 1'b1)
      $display("FAIL reset_wready got=%b%b exp=11", ref_wready, cur_wready); else pass_cnt++;
  endtask

  task automatic test_basic();
    step(1, {4{16'h1111}}, 0, 1, 32'hAAAA0001, 0);
    step(1, {4{16'h2222}}, 0, 0, 32'h0, 0);
    chk_cnt++; if (ref_level !== 4'd2) $display("FAIL basic_ref_level got=%0d exp=2", ref_level); else pass_cnt++;
    chk_cnt++; if (cur_level !== 3'd1) $display("FAIL basic_cur_level got=%0d exp=1", cur_level); else pass_cnt++;
    step(0, 64'h0, 1, 0, 32'h0, 1);
    chk_cnt++; if (ref_in !== r_exp_in || r_exp_in !== {4{16'h1111}})
      $display("FAIL basic_pop1 got=%h exp=%h", ref_in, r_exp_in); else pass_cnt++;
    chk_cnt++; if (cur_in !== c_exp_in) $display("FAIL basic_cur_pop got=%h exp=%h", cur_in, c_exp_in); else pass_cnt++;
    step(0, 64'h0, 1, 0, 32'h0, 0);
    chk_cnt++; if (ref_in !== r_exp_in) $display("FAIL basic_pop2 got=%h exp=%h", ref_in, r_exp_in); else pass_cnt++;
    chk_cnt++; if (ref_level !== 4'd0 || ref_underrun !== 1'b0)
      $display("FAIL basic_drained got lvl=%0d urun=%b exp lvl=0 urun=0", ref_level, ref_underrun); else pass_cnt++;
  endtask

  task automatic test_full();
    logic [63:0] w9;
    w9 = 64'h9999_0000_0000_0009;
    for (int i = 0; i < 8; i++) step(1, 64'h1000_0000_0000_0000 + 64'(i), 0, 0, 32'h0, 0);
    chk_cnt++; if (ref_wready !== 1'b0 || ref_level !== 4'd8)
      $display("FAIL full_state got rdy=%b lvl=%0d exp rdy=0 lvl=8", ref_wready, ref_level); else pass_cnt++;
    step(1, w9, 0, 0, 32'h0, 0);
    chk_cnt++; if (ref_level !== 4'(r_exp_q.size()))
      $display("FAIL full_hold_lvl got=%0d exp=%0d", ref_level, r_exp_q.size()); else pass_cnt++;
    step(1, w9, 1, 0, 32'h0, 0);
    chk_cnt++; if (ref_in !== r_exp_in) $display("FAIL full_pop0 got=%h exp=%h", ref_in, r_exp_in); else pass_cnt++;
    chk_cnt++; if (ref_wready !== 1'b1 || ref_level !== 4'd7)
      $display("FAIL full_after_pop got rdy=%b lvl=%0d exp rdy=1 lvl=7", ref_wready, ref_level); else pass_cnt++;
    step(1, w9, 0, 0, 32'h0, 0);
    chk_cnt++; if (ref_level !== 4'd8) $display("FAIL full_accept9 got=%0d exp=8", ref_level); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      step(0, 64'h0, 1, 0, 32'h0, 0);
      chk_cnt++; if (ref_in !== r_exp_in) $display("FAIL full_drain%0d got=%h exp=%h", i, ref_in, r_exp_in); else pass_cnt++;
    end
    chk_cnt++; if (ref_in !== w9) $display("FAIL full_last got=%h exp=%h", ref_in, w9); else pass_cnt++;
  endtask

  task automatic test_underrun();
    logic [63:0] prev;
    prev = ref_in;
    step(0, 64'h0, 1, 0, 32'h0, 0);
    chk_cnt++; if (ref_in !== prev) $display("FAIL urun_hold got=%h exp=%h", ref_in, prev); else pass_cnt++;
    chk_cnt++; if (ref_underrun !== 1'b1) $display("FAIL urun_set got=%b exp=1", ref_underrun); else pass_cnt++;
    step(1, 64'h7777, 0, 0, 32'h0, 0);
    step(0, 64'h0, 1, 0, 32'h0, 0);
    chk_cnt++; if (ref_underrun !== 1'b1) $display("FAIL urun_sticky got=%b exp=1", ref_underrun); else pass_cnt++;
    chk_cnt++; if (cur_underrun !== 1'b0) $display("FAIL urun_cur got=%b exp=0", cur_underrun); else pass_cnt++;
  endtask

  task automatic test_push_pop();
    int k;
    for (int i = 0; i < 3; i++) step(1, 64'hB000_0000_0000_0000 + 64'(i), 0, 0, 32'h0, 0);
    step(1, 64'hB000_0000_0000_0003, 1, 0, 32'h0, 0);
    chk_cnt++; if (ref_level !== 4'd3) $display("FAIL pp_level got=%0d exp=3", ref_level); else pass_cnt++;
    chk_cnt++; if (ref_in !== r_exp_in) $display("FAIL pp_order got=%h exp=%h", ref_in, r_exp_in); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step(0, 64'h0, 1, 0, 32'h0, 0);
      chk_cnt++; if (ref_in !== r_exp_in) $display("FAIL pp_drain%0d got=%h exp=%h", i, ref_in, r_exp_in); else pass_cnt++;
    end
    // 20 sequential words with random cur traffic alongside to wrap both pointer sets.
    k = 0;
    step(1, 64'hC000_0000_0000_0000 + 64'(k), 0, 0, 32'h0, 0); k++;
    step(1, 64'hC000_0000_0000_0000 + 64'(k), 0, 0, 32'h0, 0); k++;
    for (int i = 0; i < 20; i++) begin
      logic cv, cr;
      cv = 1'($urandom_range(0, 1));
      cr = (c_exp_q.size() != 0) && 1'($urandom_range(0, 1));
      step(k < 20, 64'hC000_0000_0000_0000 + 64'(k), 1, cv, $urandom, cr);
      if (k < 20) k++;
      chk_cnt++; if (ref_in !== r_exp_in) $display("FAIL stream%0d got=%h exp=%h", i, ref_in, r_exp_in); else pass_cnt++;
      chk_cnt++; if (cur_in !== c_exp_in || cur_level !== 3'(c_exp_q.size()))
        $display("FAIL stream_cur%0d got=%h/%0d exp=%h/%0d", i, cur_in, cur_level, c_exp_in, c_exp_q.size()); else pass_cnt++;
    end
    chk_cnt++; if (ref_in !== 64'hC000_0000_0000_0013) $display("FAIL stream_last got=%h exp=c000000000000013", ref_in); else pass_cnt++;
  endtask

  task automatic test_empty_pushpop();
    logic [63:0] prev;
    apply_reset();
    prev = ref_in;
    step(1, {4{16'h5A5A}}, 1, 0, 32'h0, 0);
`ifdef ME_FETCH_BYPASS_EN
    chk_cnt++; if (ref_in !== {4{16'h5A5A}}) $display("FAIL byp_in got=%h exp=5a5a5a5a5a5a5a5a", ref_in); else pass_cnt++;
    chk_cnt++; if (ref_level !== 4'd0 || ref_underrun !== 1'b0)
      $display("FAIL byp_state got lvl=%0d urun=%b exp lvl=0 urun=0", ref_level, ref_underrun); else pass_cnt++;
`else
    chk_cnt++; if (ref_in !== prev) $display("FAIL epp_in got=%h exp=%h", ref_in, prev); else pass_cnt++;
    chk_cnt++; if (ref_level !== 4'd1 || ref_underrun !== 1'b1)
      $display("FAIL epp_state got lvl=%0d urun=%b exp lvl=1 urun=1", ref_level, ref_underrun); else pass_cnt++;
    step(0, 64'h0, 1, 0, 32'h0, 0);
    chk_cnt++; if (ref_in !== {4{16'h5A5A}}) $display("FAIL epp_stored got=%h exp=5a5a5a5a5a5a5a5a", ref_in); else pass_cnt++;
`endif
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) step(1, 64'hD000_0000_0000_0000 + 64'(i), 0, 1, 32'hCC00_0000 + 32'(i), 0);
    step(0, 64'h0, 1, 0, 32'h0, 1);
    chk_cnt++; if (ref_level !== 4'd5 || ref_in !== r_exp_in)
      $display("FAIL ar_pre got lvl=%0d in=%h exp lvl=5 in=%h", ref_level, ref_in, r_exp_in); else pass_cnt++;
    #2;
    rstn = 1'b0;
    #1;
    chk_cnt++; if (ref_in !== 64'h0 || cur_in !== 32'h0)
      $display("FAIL ar_data got=%h/%h exp=0/0", ref_in, cur_in); else pass_cnt++;
    chk_cnt++; if (ref_level !== 4'd0 || cur_level !== 3'd0)
      $display("FAIL ar_level got=%0d/%0d exp=0/0", ref_level, cur_level); else pass_cnt++;
    chk_cnt++; if (ref_underrun !== 1'b0 || cur_underrun !== 1'b0)
      $display("FAIL ar_flags got=%b/%b exp=0/0", ref_underrun, cur_underrun); else pass_cnt++;
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    step(0, 64'h0, 1, 0, 32'h0, 0);
    chk_cnt++; if (ref_underrun !== 1'b1 || ref_in !== 64'h0)
      $display("FAIL ar_flushed got urun=%b in=%h exp urun=1 in=0", ref_underrun, ref_in); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_underrun();
    test_push_pop();
    test_empty_pushpop();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
